// File: rtl/gpio_bus_master.sv
// gpio_bus_master: single-command initiator for the GPIO register bus.
// Takes write / read / set-bits / clear-bits commands from a valid/ready port, runs the
// register bus cycle by cycle and returns one response per command.
// Optional build macro GPIO_MASTER_IRQ_SERVICE_EN adds an interrupt service sequence
// (read then clear of the status register at 0x14) that pre-empts commands in IDLE.
module gpio_bus_master #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     WRITE,
  output logic [ADDRESS_WIDTH-1:0] ADDRESS,
  output logic [DATA_WIDTH-1:0]    WDATA,
  input  logic [DATA_WIDTH-1:0]    RDATA,
`ifdef GPIO_MASTER_IRQ_SERVICE_EN
  output logic                     irq_valid,
  output logic [DATA_WIDTH-1:0]    irq_status,
`endif
  input  logic [DATA_WIDTH-1:0]    GPIO_INTR
);

  // READ_LATENCY is at most 7, so three bits cover the wait counter.
  localparam int unsigned CntW = 3;
  localparam logic [CntW-1:0] CntLoad = CntW'(READ_LATENCY);
  localparam logic [ADDRESS_WIDTH-1:0] IrqStatusAddr = ADDRESS_WIDTH'(32'h14);

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpSet   = 2'b10;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               op_q, op_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    mask_q, mask_d;
  logic                     write_q, write_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic                     rsp_err_q, rsp_err_d;
  logic                     svc_q, svc_d;
  logic                     irq_valid_q, irq_valid_d;
  logic [DATA_WIDTH-1:0]    irq_status_q, irq_status_d;
  logic                     irq_req;
  logic                     cmd_fire;

`ifdef GPIO_MASTER_IRQ_SERVICE_EN
  assign irq_req    = |GPIO_INTR;
  assign irq_valid  = irq_valid_q;
  assign irq_status = irq_status_q;
`else
  // Without the service feature the interrupt lines are deliberately ignored.
  logic unused_intr;
  logic unused_irq_state;
  assign unused_intr      = ^GPIO_INTR;
  assign unused_irq_state = irq_valid_q ^ (^irq_status_q);
  assign irq_req          = 1'b0;
`endif

  // Command port opens only in IDLE, out of reset, and when no interrupt is pending.
  assign cmd_ready = (state_q == StIdle) && !rst && !irq_req;
  assign cmd_fire  = cmd_valid && cmd_ready;

  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign WRITE     = write_q;
  assign ADDRESS   = addr_q;
  assign WDATA     = wdata_q;

  // Next-state and next-output computation for the bus sequencer.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    write_d      = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    svc_d        = svc_q;
    irq_valid_d  = 1'b0;
    irq_status_d = irq_status_q;

    unique case (state_q)
      StIdle: begin
        if (irq_req) begin
          state_d = StRd;
          addr_d  = IrqStatusAddr;
          cnt_d   = CntLoad;
          svc_d   = 1'b1;
        end else if (cmd_fire) begin
          op_d       = cmd_op;
          mask_d     = cmd_data;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if (cmd_addr[1:0] != 2'b00) begin
            // Misaligned: answer with an error and leave the bus untouched.
            rsp_err_d = 1'b1;
            state_d   = StResp;
          end else if (cmd_op == OpWrite) begin
            state_d = StWr;
            write_d = 1'b1;
            addr_d  = cmd_addr;
            wdata_d = cmd_data;
          end else begin
            state_d = StRd;
            addr_d  = cmd_addr;
            cnt_d   = CntLoad;
          end
        end
      end

      StRd: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (svc_q) begin
          // Interrupt service: report the captured status and clear it.
          irq_status_d = RDATA;
          irq_valid_d  = 1'b1;
          wdata_d      = '0;
          write_d      = 1'b1;
          state_d      = StWr;
        end else begin
          rsp_data_d = RDATA;
          if (op_q == OpRead) begin
            state_d = StResp;
          end else begin
            wdata_d = (op_q == OpSet) ? (RDATA | mask_q) : (RDATA & ~mask_q);
            write_d = 1'b1;
            state_d = StWr;
          end
        end
      end

      StWr: begin
        if (svc_q) begin
          svc_d   = 1'b0;
          state_d = StIdle;
        end else begin
          state_d = StResp;
        end
      end

      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset discards any in-flight command or response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      op_q         <= 2'b00;
      cnt_q        <= '0;
      mask_q       <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      svc_q        <= 1'b0;
      irq_valid_q  <= 1'b0;
      irq_status_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      svc_q        <= svc_d;
      irq_valid_q  <= irq_valid_d;
      irq_status_q <= irq_status_d;
    end
  end

endmodule

// File: tb/tb_gpio_bus_master.sv
// tb_gpio_bus_master: directed bench for gpio_bus_master with a small GPIO register model
// (READ_LATENCY = 1). Define GPIO_MASTER_IRQ_SERVICE_EN to cover the interrupt service path.
module tb_gpio_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [31:0] gpio_intr;
`ifdef GPIO_MASTER_IRQ_SERVICE_EN
  logic        irq_valid;
  logic [31:0] irq_status;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int w0;

  logic [31:0] mem [0:7];

  always #5 clk = ~clk;

  gpio_bus_master #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (32),
    .READ_LATENCY  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .WRITE     (bus_write),
    .ADDRESS   (bus_addr),
    .WDATA     (bus_wdata),
    .RDATA     (bus_rdata),
`ifdef GPIO_MASTER_IRQ_SERVICE_EN
    .irq_valid (irq_valid),
    .irq_status(irq_status),
`endif
    .GPIO_INTR (gpio_intr)
  );

  // GPIO register model: one-cycle read latency, 0x14 reads the interrupt lines.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) mem[k] <= 32'h0;
      mem[2]    <= 32'h1234_5678;
      mem[4]    <= 32'h0000_00F0;
      bus_rdata <= 32'h0;
    end else begin
      if (bus_write) begin
        mem[bus_addr[4:2]] <= bus_wdata;
        wr_count           <= wr_count + 1;
      end
      bus_rdata <= (bus_addr[4:2] == 3'd5) ? gpio_intr : mem[bus_addr[4:2]];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = 32'h0;
    cmd_data  = 32'h0;
    rsp_ready = 1'b1;
    gpio_intr = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_rsp_data", rsp_data, 32'h0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_write", 32'(bus_write), 32'h0);
    check_eq("rst_address", bus_addr, 32'h0);
    check_eq("rst_wdata", bus_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Plain write
    check_eq("idle_cmd_ready", 32'(cmd_ready), 32'h1);
    w0 = wr_count;
    drive_cmd(2'b00, 32'h04, 32'hA5A5_0F0F);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("wr_write", 32'(bus_write), 32'h1);
    check_eq("wr_address", bus_addr, 32'h04);
    check_eq("wr_wdata", bus_wdata, 32'hA5A5_0F0F);
    check_eq("wr_busy", 32'(busy), 32'h1);
    check_eq("wr_early_rsp", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    check_eq("wr_write_off", 32'(bus_write), 32'h0);
    check_eq("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("wr_rsp_data", rsp_data, 32'h0);
    check_eq("wr_rsp_err", 32'(rsp_err), 32'h0);
    @(negedge clk);
    check_eq("wr_rsp_done", 32'(rsp_valid), 32'h0);
    check_eq("wr_back_idle", 32'(cmd_ready), 32'h1);
    check_eq("wr_one_pulse", 32'(wr_count - w0), 32'h1);

    // Read of 0x08
    drive_cmd(2'b01, 32'h08, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("rd_write_c1", 32'(bus_write), 32'h0);
    check_eq("rd_address_c1", bus_addr, 32'h08);
    check_eq("rd_rsp_c1", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    check_eq("rd_write_c2", 32'(bus_write), 32'h0);
    check_eq("rd_address_c2", bus_addr, 32'h08);
    check_eq("rd_rsp_c2", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    check_eq("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("rd_rsp_data", rsp_data, 32'h1234_5678);
    check_eq("rd_rsp_err", 32'(rsp_err), 32'h0);
    @(negedge clk);

    // RMW set then clear on 0x10 (holds 0xF0)
    w0 = wr_count;
    drive_cmd(2'b10, 32'h10, 32'h0F);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("set_no_write_c1", 32'(bus_write), 32'h0);
    @(negedge clk);
    check_eq("set_no_write_c2", 32'(bus_write), 32'h0);
    @(negedge clk);
    check_eq("set_write", 32'(bus_write), 32'h1);
    check_eq("set_address", bus_addr, 32'h10);
    check_eq("set_wdata", bus_wdata, 32'h0000_00FF);
    @(negedge clk);
    check_eq("set_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("set_rsp_data", rsp_data, 32'h0000_00F0);
    @(negedge clk);
    drive_cmd(2'b11, 32'h10, 32'h30);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("clr_write", 32'(bus_write), 32'h1);
    check_eq("clr_wdata", bus_wdata, 32'h0000_00CF);
    @(negedge clk);
    check_eq("clr_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("clr_rsp_data", rsp_data, 32'h0000_00FF);
    @(negedge clk);
    check_eq("rmw_two_writes", 32'(wr_count - w0), 32'h2);

    // Response backpressure
    rsp_ready = 1'b0;
    drive_cmd(2'b01, 32'h10, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check_eq("bp_rsp_data", rsp_data, 32'h0000_00CF);
      check_eq("bp_cmd_ready", 32'(cmd_ready), 32'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_released", 32'(rsp_valid), 32'h0);

    // Misaligned read: error response, no bus activity
    w0 = wr_count;
    drive_cmd(2'b01, 32'h06, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("mis_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("mis_rsp_err", 32'(rsp_err), 32'h1);
    check_eq("mis_rsp_data", rsp_data, 32'h0);
    check_eq("mis_write", 32'(bus_write), 32'h0);
    check_eq("mis_address", bus_addr, 32'h10);
    @(negedge clk);
    check_eq("mis_rsp_done", 32'(rsp_valid), 32'h0);
    check_eq("mis_no_write", 32'(wr_count - w0), 32'h0);

    // Reset in the middle of a read
    drive_cmd(2'b01, 32'h08, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_write", 32'(bus_write), 32'h0);
    check_eq("mid_rst_address", bus_addr, 32'h0);
    check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    check_eq("mid_rst_cmd_ready", 32'(cmd_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_cmd(2'b01, 32'h08, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("post_rst_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("post_rst_rsp_data", rsp_data, 32'h1234_5678);
    @(negedge clk);

`ifdef GPIO_MASTER_IRQ_SERVICE_EN
    // Interrupt service pre-empts a waiting command
    gpio_intr = 32'h1;
    drive_cmd(2'b01, 32'h08, 32'h0);
    #1;
    check_eq("irq_block_cmd", 32'(cmd_ready), 32'h0);
    @(negedge clk);
    check_eq("irq_rd_address", bus_addr, 32'h14);
    check_eq("irq_rd_write", 32'(bus_write), 32'h0);
    check_eq("irq_rd_cmd_ready", 32'(cmd_ready), 32'h0);
    @(negedge clk);
    check_eq("irq_valid_early", 32'(irq_valid), 32'h0);
    @(negedge clk);
    check_eq("irq_wr_write", 32'(bus_write), 32'h1);
    check_eq("irq_wr_address", bus_addr, 32'h14);
    check_eq("irq_wr_wdata", bus_wdata, 32'h0);
    check_eq("irq_valid", 32'(irq_valid), 32'h1);
    check_eq("irq_status", irq_status, 32'h1);
    check_eq("irq_no_rsp", 32'(rsp_valid), 32'h0);
    gpio_intr = 32'h0;
    @(negedge clk);
    check_eq("irq_valid_pulse", 32'(irq_valid), 32'h0);
    check_eq("irq_no_rsp_after", 32'(rsp_valid), 32'h0);
    check_eq("irq_cmd_ready", 32'(cmd_ready), 32'h1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("irq_cmd_address", bus_addr, 32'h08);
    @(negedge clk);
    @(negedge clk);
    check_eq("irq_cmd_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("irq_cmd_rsp_data", rsp_data, 32'h1234_5678);
    @(negedge clk);
`else
    // Interrupt lines have no effect in the default build
    gpio_intr = 32'hFFFF_FFFF;
    drive_cmd(2'b01, 32'h08, 32'h0);
    #1;
    check_eq("noirq_cmd_ready", 32'(cmd_ready), 32'h1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("noirq_address", bus_addr, 32'h08);
    @(negedge clk);
    @(negedge clk);
    check_eq("noirq_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("noirq_rsp_data", rsp_data, 32'h1234_5678);
    gpio_intr = 32'h0;
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_bus_master.md
Name: gpio_bus_master

Overview:
- Initiator for the GPIO register interface (WRITE/ADDRESS/WDATA/RDATA).
- Accepts single commands from an upstream valid/ready port: write, read, set-bits or clear-bits read-modify-write.
- Sequences the GPIO register bus cycle-accurately and returns one response per command.
- Sits between the control processor/sequencer and the GPIO block.

Parameters:
- DATA_WIDTH, 32, register data width; matches the GPIO block.
- ADDRESS_WIDTH, 32, register address width.
- READ_LATENCY, 1, cycles from ADDRESS presented (WRITE=0) to RDATA valid; legal range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_op  in  2  00 write, 01 read, 10 RMW set (old|data), 11 RMW clear (old&~data).
- cmd_addr  in  ADDRESS_WIDTH  register byte address.
- cmd_data  in  DATA_WIDTH  write data or bit mask.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_data  out  DATA_WIDTH  read data; old value for RMW; 0 for write.
- rsp_err  out  1  misaligned address; no bus access made.
- busy  out  1  state != IDLE.
- WRITE  out  1  to GPIO WRITE.
- ADDRESS  out  ADDRESS_WIDTH  to GPIO ADDRESS.
- WDATA  out  DATA_WIDTH  to GPIO WDATA.
- RDATA  in  DATA_WIDTH  from GPIO RDATA.
- GPIO_INTR  in  DATA_WIDTH  from GPIO; used only with the optional feature.

Behaviour:
- Reset (async, rst=1): state IDLE; cmd_ready=0 while rst=1; rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, WRITE=0, ADDRESS=0, WDATA=0.
- Reset mid-operation: in-flight command and any pending response are discarded; no partial write is re-issued.
- All bus outputs are registered.
- WRITE=1 for exactly one cycle per write phase; otherwise 0.
- ADDRESS holds its last value between commands.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept with cmd_addr[1:0]!=0: go to RESP with rsp_err=1, rsp_data=0; no bus access.
  - On accept of an aligned op 00: go to WR; next cycle WRITE=1, ADDRESS=cmd_addr, WDATA=cmd_data.
  - On accept of aligned ops 01/10/11: go to RD; next cycle WRITE=0, ADDRESS=cmd_addr.
- RD:
  - Holds WRITE=0 and ADDRESS for READ_LATENCY+1 cycles.
  - Counter loads READ_LATENCY on entry and decrements.
  - On the cycle the counter is 0, captures RDATA into the old-value register.
  - Next state: op 01 goes to RESP. Ops 10/11 go to WR with WDATA=old|mask (10) or old&~mask (11).
- WR: one cycle with WRITE=1, then RESP.
  - rsp_data = 0 for op 00; old value for RMW.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err held stable until rsp_ready.
  - On handshake go to IDLE.
  - cmd_ready=0 throughout RESP.
- Latency with rsp_ready=1 (accept cycle to rsp_valid):
  - write: 2 cycles.
  - read: READ_LATENCY+2 cycles.
  - RMW: READ_LATENCY+3 cycles.
- One command outstanding at a time; no pipelining.
- Commands with an unmapped aligned address are passed through unchanged; the GPIO block ignores them.

Optional Feature:
GPIO_MASTER_IRQ_SERVICE_EN
- Defined:
  - Adds an output irq_valid (1) and an output irq_status (DATA_WIDTH).
  - In IDLE, when |GPIO_INTR=1, interrupt service takes priority over cmd_valid.
  - Service sequence: read of 0x14 (RD), then write of 0 to 0x14 (WR), then IDLE. No rsp_valid is produced.
  - irq_valid pulses for one cycle in the WR cycle; irq_status = captured value.
  - cmd_ready=0 during service.
- Not defined: the irq ports are absent, GPIO_INTR is ignored, and there is no service sequence.

Test Plan:
- Write: cmd op=00, addr=0x04, data=0xA5A5_0F0F → exactly one cycle WRITE=1/ADDRESS=0x04/WDATA=0xA5A5_0F0F; rsp_valid 2 cycles after accept with rsp_data=0, rsp_err=0.
- Read: GPIO model returns 0x1234_5678 for 0x08; op=01 → WRITE stays 0, ADDRESS=0x08 for 2 cycles; rsp_data=0x1234_5678 at accept+3.
- RMW set/clear: reg 0x10 holds 0x0000_00F0.
  - op=10 mask 0x0F → write 0x0000_00FF, rsp_data=0xF0.
  - Then op=11 mask 0x30 → write 0x0000_00CF.
- Backpressure and misalignment:
  - rsp_ready=0 for 5 cycles → rsp_valid/rsp_data stable, cmd_ready=0.
  - op=01 addr=0x06 → rsp_err=1, rsp_data=0, no bus activity.
- Reset mid-read: assert rst during RD → WRITE=0, ADDRESS=0, rsp_valid=0 immediately; after release the next read completes normally.
- IRQ service (macro defined): GPIO_INTR=0x1 with cmd_valid=1 in IDLE → read 0x14 then write 0 to 0x14 first, irq_valid pulse with irq_status=0x1; the command is accepted afterwards.
